aes128_encrypt_iter: RTL and testbench

Iterative AES-128 encryption engine: accepts one plaintext block and cipher key over a valid/ready handshake, runs the 10 FIPS-197 rounds one per clock with on-the-fly key expansion, and presents the ciphertext over a second valid/ready handshake. It is the transmit-side counterpart to the pipelined decryption datapath. It trades throughput for area: one block in flight, no externally supplied round keys. Its optional last-round-key output feeds the decrypt side's key inputs.

---
 rtl/aes128_encrypt_iter.sv | 221 ++++++++++++++++++++++
 tb/tb_aes128_encrypt_iter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_iter.sv
// aes128_encrypt_iter: iterative AES-128 encryption engine, one round per clock.
// A plaintext block and key are accepted on a valid/ready handshake. Ten rounds
// then run with on-the-fly key expansion. The ciphertext is held until the
// downstream side accepts it.
// Optional feature macro: AES_ENC_LAST_KEY_OUT_EN adds the last_round_key port,
// which carries the round-10 key for the decrypt side.
`timescale 1ns/1ps

module aes128_encrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain_text,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher_text,
  output logic         busy
`ifdef AES_ENC_LAST_KEY_OUT_EN
  ,
  output logic [127:0] last_round_key
`endif
);

  localparam int unsigned BLK_W   = 128;
  localparam int unsigned RND_W   = 4;
  localparam int unsigned NUM_RND = 10;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ROUND = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Byte 0 of the block is the most significant byte; column c holds bytes 4c..4c+3.
  typedef logic [0:15][7:0] block_t;

  localparam logic [0:255][7:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16
  };

  logic [1:0]       fsm_state;
  logic [1:0]       fsm_next;
  logic             accept;
  block_t           state_reg;
  logic [BLK_W-1:0] rk_reg;
  logic [RND_W-1:0] rnd;
  logic [BLK_W-1:0] rk_next;
  block_t           sr_out;
  block_t           round_out;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for the key schedule step that produces round key r.
  function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Four S-box lookups on one key word.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Derive the next round key from the current one.
  function automatic logic [BLK_W-1:0] expand_key(input logic [BLK_W-1:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // S-box applied to all 16 state bytes.
  function automatic block_t sub_bytes(input block_t b);
    block_t r;
    for (int i = 0; i < 16; i++) begin
      r[4'(i)] = SBOX[b[4'(i)]];
    end
    return r;
  endfunction

  // Row r rotates left by r byte positions across the columns.
  function automatic block_t shift_rows(input block_t b);
    block_t r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[4'(row + 4 * c)] = b[4'(row + 4 * ((c + row) % 4))];
      end
    end
    return r;
  endfunction

  // Column mixing with the fixed {02,03,01,01} circulant matrix.
  function automatic block_t mix_columns(input block_t b);
    block_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = b[4'(4 * c)];
      a1 = b[4'(4 * c + 1)];
      a2 = b[4'(4 * c + 2)];
      a3 = b[4'(4 * c + 3)];
      r[4'(4 * c)]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[4'(4 * c + 1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[4'(4 * c + 2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[4'(4 * c + 3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_state <= ST_IDLE;
    end else begin
      fsm_state <= fsm_next;
    end
  end

  // Next-state and load decode; DONE can hand off straight into a new block.
  always_comb begin
    fsm_next = fsm_state;
    accept   = 1'b0;
    case (fsm_state)
      ST_IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          fsm_next = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (rnd == RND_W'(NUM_RND)) begin
          fsm_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            accept   = 1'b1;
            fsm_next = ST_ROUND;
          end else begin
            fsm_next = ST_IDLE;
          end
        end
      end
      default: fsm_next = ST_IDLE;
    endcase
  end

  // One full cipher round plus key-schedule step; the final round skips MixColumns.
  always_comb begin
    rk_next   = expand_key(rk_reg, rcon(rnd));
    sr_out    = shift_rows(sub_bytes(state_reg));
    round_out = (rnd == RND_W'(NUM_RND)) ? (sr_out ^ rk_next)
                                         : (mix_columns(sr_out) ^ rk_next);
  end

  // Datapath registers: load on accept, advance one round per cycle in ROUND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      rk_reg    <= '0;
      rnd       <= '0;
    end else if (accept) begin
      state_reg <= plain_text ^ key;
      rk_reg    <= key;
      rnd       <= RND_W'(1);
    end else if (fsm_state == ST_ROUND) begin
      state_reg <= round_out;
      rk_reg    <= rk_next;
      rnd       <= RND_W'(rnd + RND_W'(1));
    end
  end

`ifdef AES_ENC_LAST_KEY_OUT_EN
  // Capture the round-10 key for the decrypt side; holds until the next block's final round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_round_key <= '0;
    end else if (fsm_state == ST_ROUND && rnd == RND_W'(NUM_RND)) begin
      last_round_key <= rk_next;
    end
  end
`endif

  // Status decoded from state; ciphertext is masked so intermediate rounds never leave the core.
  assign in_ready    = (fsm_state == ST_IDLE) ||
                       (fsm_state == ST_DONE && out_ready && in_valid);
  assign out_valid   = (fsm_state == ST_DONE);
  assign busy        = (fsm_state != ST_IDLE);
  assign cipher_text = (fsm_state == ST_DONE) ? BLK_W'(state_reg) : '0;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter: a FIPS-197 reference model
// (S-box derived from the GF(2^8) inverse) plus a per-cycle protocol model.
`timescale 1ns/1ps

module tb_aes128_encrypt_iter;

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BL  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher_text;
  logic         busy;
`ifdef AES_ENC_LAST_KEY_OUT_EN
  logic [127:0] last_round_key;
`endif

  aes128_encrypt_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plain_text(plain_text), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .cipher_text(cipher_text), .busy(busy)
`ifdef AES_ENC_LAST_KEY_OUT_EN
    , .last_round_key(last_round_key)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acc_q[$];
  logic [127:0] out_q[$];
  logic [7:0] sbm [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Textbook AES-128 encryption on byte arrays with a full 44-word key schedule.
  function automatic void aes_model(input logic [127:0] pt, input logic [127:0] k,
                                    output logic [127:0] ct, output logic [127:0] lrk);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp, rkw;
    logic [7:0]  rc, a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {sbm[tmp[23:16]], sbm[tmp[15:8]], sbm[tmp[7:0]], sbm[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) begin
      rkw  = w[i / 4];
      s[i] = pt[127 - 8 * i -: 8] ^ rkw[31 - 8 * (i % 4) -: 8];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbm[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row + 4 * c] = s[row + 4 * ((c + row) % 4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
        if (r < 10) begin
          s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) begin
        rkw  = w[4 * r + i / 4];
        s[i] = s[i] ^ rkw[31 - 8 * (i % 4) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = s[i];
    lrk = {w[40], w[41], w[42], w[43]};
  endfunction

  // Protocol model: 0 idle, 1 computing (m_cnt rounds left), 2 result held.
  int           m_st  = 0;
  int           m_cnt = 0;
  logic [127:0] m_ct  = '0;
  logic [127:0] m_lrk = '0;
  logic [127:0] m_lrk_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st  = 0;
      m_cnt = 0;
      m_lrk = '0;
    end else begin
      case (m_st)
        0: if (in_valid) begin
             aes_model(plain_text, key, m_ct, m_lrk_pend);
             m_cnt = 10;
             m_st  = 1;
           end
        1: begin
             m_cnt--;
             if (m_cnt == 0) begin
               m_st  = 2;
               m_lrk = m_lrk_pend;
             end
           end
        default: if (out_ready) begin
             if (in_valid) begin
               aes_model(plain_text, key, m_ct, m_lrk_pend);
               m_cnt = 10;
               m_st  = 1;
             end else begin
               m_st = 0;
             end
           end
      endcase
    end
  end

  // Handshake monitor.
  always @(posedge clk) begin
    cyc++;
    if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
    if (!rst && out_valid && out_ready) out_q.push_back(cipher_text);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 128'(out_valid), 128'(m_st == 2));
      chk("busy", 128'(busy), 128'(m_st != 0));
      chk("in_ready", 128'(in_ready), 128'(m_st == 0 || (m_st == 2 && out_ready && in_valid)));
      if (m_st == 2) chk("cipher_text", cipher_text, m_ct);
`ifdef AES_ENC_LAST_KEY_OUT_EN
      chk("last_round_key", last_round_key, m_lrk);
`endif
    end
  end

  // Wait for out_valid at a negedge; returns the number of rising edges waited.
  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) chk({name, "_timeout"}, 128'(out_valid), 128'(1));
  endtask

  task automatic offer(input logic [127:0] p, input logic [127:0] k);
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    plain_text = p;
    key        = k;
  endtask

  task automatic handshake_out();
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] ct, lrk;
    logic [7:0]   inv;
    int           n, a0, o0, k;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] ct, lrk;
    logic [7:0]   inv;
    int           n, a0, o0, k;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plain_text = '0; key = '0;

    // S-box from the multiplicative inverse and the affine map.
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbm[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    // Pin the model to the published vectors.
    aes_model(C1P, C1K, ct, lrk);
    chk("model_c1_ct", ct, C1C);
    aes_model(BP, BK, ct, lrk);
    chk("model_b_ct", ct, BC);
    chk("model_b_lrk", lrk, BL);

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_cipher_text", cipher_text, '0);
`ifdef AES_ENC_LAST_KEY_OUT_EN
    chk("rst_last_round_key", last_round_key, '0);
`endif

    // C.1 vector, 10-cycle latency.
    offer(C1P, C1K);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid("c1", n);
    chk("c1_latency", 128'(n), 128'(10));
    chk("c1_ct", cipher_text, C1C);
    handshake_out();

    // B vector with 20 cycles of backpressure.
    o0 = out_q.size();
    offer(BP, BK);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid("b", n);
    chk("b_latency", 128'(n), 128'(10));
    chk("b_ct", cipher_text, BC);
`ifdef AES_ENC_LAST_KEY_OUT_EN
    chk("b_lrk", last_round_key, BL);
`endif
    repeat (20) begin
      @(negedge clk);
      chk("bp_ct_stable", cipher_text, BC);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_busy", 128'(busy), 128'(1));
    end
    handshake_out();
    @(negedge clk);
    chk("bp_idle_valid", 128'(out_valid), 128'(0));
    chk("bp_idle_busy", 128'(busy), 128'(0));
    chk("bp_one_handshake", 128'(out_q.size()), 128'(o0 + 1));

    // Back-to-back with input toggling during the rounds.
    a0 = acc_q.size();
    o0 = out_q.size();
    offer(C1P, C1K);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      plain_text = {$urandom, $urandom, $urandom, $urandom};
      key        = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    plain_text = BP;
    key        = BK;
    k = 0;
    while (acc_q.size() < a0 + 2 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    in_valid = 1'b0;
    k = 0;
    while (out_q.size() < o0 + 2 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    out_ready = 1'b0;
    if (acc_q.size() >= a0 + 2)
      chk("b2b_accept_spacing", 128'(acc_q[a0 + 1] - acc_q[a0]), 128'(11));
    else
      chk("b2b_accept_count", 128'(acc_q.size() - a0), 128'(2));
    if (out_q.size() >= o0 + 2) begin
      chk("b2b_first_ct", out_q[o0], C1C);
      chk("b2b_second_ct", out_q[o0 + 1], BC);
    end else begin
      chk("b2b_out_count", 128'(out_q.size() - o0), 128'(2));
    end

    // in_valid held high through ROUND and DONE: only one accept.
    a0 = acc_q.size();
    o0 = out_q.size();
    offer(C1P, C1K);
    wait_valid("hold", n);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_one_accept", 128'(acc_q.size()), 128'(a0 + 1));
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_one_output", 128'(out_q.size()), 128'(o0 + 1));
    if (out_q.size() == o0 + 1) chk("hold_ct", out_q[o0], C1C);

    // Reset during round 5, then a clean B block.
    offer(BP, BK);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_cipher_text", cipher_text, '0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    o0 = out_q.size();
    offer(BP, BK);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid("post_rst", n);
    chk("post_rst_latency", 128'(n), 128'(10));
    chk("post_rst_ct", cipher_text, BC);
`ifdef AES_ENC_LAST_KEY_OUT_EN
    chk("post_rst_lrk", last_round_key, BL);
`endif
    handshake_out();
    @(negedge clk);
    chk("post_rst_outputs", 128'(out_q.size()), 128'(o0 + 1));

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
